// File: rtl/fifo_flops_flags_if.sv
// Producer/consumer bundle for fifo_flops_flags: push/pop handshake, data and status.
// master drives requests and write data; slave (the FIFO) drives read data and flags.
interface fifo_flops_flags_if #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned BITS  = 16
) ();
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [BITS-1:0] Din;
    logic            push;
    logic            pop;
    logic            clr_err;
    logic [BITS-1:0] Dout;
    logic            pndng;
    logic            full;
    logic            empty;
    logic            almost_full;
    logic            almost_empty;
    logic [CW-1:0]   count;
    logic            overflow;
    logic            underflow;

    modport master (
        output Din, push, pop, clr_err,
        input  Dout, pndng, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  Din, push, pop, clr_err,
        output Dout, pndng, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_flops_flags.sv
// Single-clock flop-array FIFO with FWFT or registered read, threshold flags,
// occupancy count and sticky overflow/underflow error flags.
module fifo_flops_flags #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned BITS   = 16,
    parameter int unsigned AF_LVL = DEPTH - 2,
    parameter int unsigned AE_LVL = 2,
    parameter bit          FWFT   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    fifo_flops_flags_if.slave bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);
    localparam logic [CW-1:0] AfLvlC = CW'(AF_LVL);
    localparam logic [CW-1:0] AeLvlC = CW'(AE_LVL);
    localparam logic [PW-1:0] LastC  = PW'(DEPTH - 1);

    logic [BITS-1:0] mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic            pop_ok, push_ok;

    // A pop on a full FIFO frees the slot the simultaneous push needs.
    assign pop_ok  = bus.pop & (count_q != '0);
    assign push_ok = bus.push & ((count_q != DepthC) | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = (wr_ptr_q == LastC) ? '0 : wr_ptr_q + PW'(1);
        if (pop_ok)  rd_ptr_d = (rd_ptr_q == LastC) ? '0 : rd_ptr_q + PW'(1);
        if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
        else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
        ovf_d = (bus.push & ~push_ok) | (ovf_q & ~bus.clr_err);
        unf_d = (bus.pop & ~pop_ok) | (unf_q & ~bus.clr_err);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is deliberately not reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= bus.Din;
    end

    generate
        if (FWFT) begin : g_fwft
            assign bus.Dout = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
        end else begin : g_reg
            logic [BITS-1:0] dout_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)        dout_q <= '0;
                else if (pop_ok) dout_q <= mem_q[rd_ptr_q];
            end
            assign bus.Dout = dout_q;
        end
    endgenerate

    assign bus.count        = count_q;
    assign bus.pndng        = (count_q != '0);
    assign bus.empty        = (count_q == '0);
    assign bus.full         = (count_q == DepthC);
    assign bus.almost_full  = (count_q >= AfLvlC);
    assign bus.almost_empty = (count_q <= AeLvlC);
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule

// File: doc/fifo_flops_flags.md
# fifo_flops_flags

Parametrised successor to the flop-based FIFO: a synchronous single-clock FIFO with a selectable read mode (first-word-fall-through or registered), programmable almost-full/almost-empty thresholds, an occupancy count output and sticky overflow/underflow error flags. It sits between a producer and a consumer wherever the existing `push`/`pop`/`pndng`/`full` handshake is used, and is a drop-in superset of that interface.

## Interface
- `DEPTH`, 16, number of entries; ≥2, need not be a power of two
- `BITS`, 16, data width
- `AF_LVL`, DEPTH-2, `almost_full` asserts when count ≥ AF_LVL
- `AE_LVL`, 2, `almost_empty` asserts when count ≤ AE_LVL
- `FWFT`, 1, 1 = head word shown on `Dout` without a pop; 0 = `Dout` registered on pop

Ports:
- `clk` in 1 — single clock, all state on rising edge
- `rst` in 1 — reset, asynchronous assert, active-low (0 = reset); deassertion is synchronous to `clk` externally
- `Din` in BITS — write data
- `push` in 1 — write request
- `pop` in 1 — read request
- `clr_err` in 1 — clears `overflow`/`underflow`
- `Dout` out BITS — read data
- `pndng` out 1 — count ≠ 0
- `full` out 1 — count == DEPTH
- `empty` out 1 — count == 0
- `almost_full` out 1 — count ≥ AF_LVL
- `almost_empty` out 1 — count ≤ AE_LVL
- `count` out $clog2(DEPTH+1) — occupancy
- `overflow` out 1 — sticky, push rejected
- `underflow` out 1 — sticky, pop rejected

## Operation
- Storage: DEPTH×BITS flop array, not reset. `wr_ptr`, `rd_ptr` each $clog2(DEPTH) bits; increment with explicit wrap DEPTH-1 → 0 (no reliance on natural rollover).
- Accept rules, evaluated on pre-edge state:
  - pop_ok = pop & (count ≠ 0)
  - push_ok = push & (count ≠ DEPTH | pop_ok)
- push_ok: mem[wr_ptr] ← Din, wr_ptr advances. pop_ok: rd_ptr advances.
- count ← count + push_ok − pop_ok. Push+pop both accepted: count unchanged, both pointers advance.
- Full + push + pop: both accepted, no overflow. Empty + push + pop: push accepted, pop rejected, underflow set, count → 1.
- Rejected operations change no pointer, count or memory.
- `overflow` ← 1 when push & ~push_ok; `underflow` ← 1 when pop & ~pop_ok. Both held until `clr_err` or reset. Set and `clr_err` in the same cycle: set wins.
- Status outputs are combinational decodes of the registered `count`.
- FWFT=1: `Dout` = mem[rd_ptr] when count ≠ 0, else all zeros (never X).
- FWFT=0: `Dout` register ← mem[rd_ptr] on pop_ok; otherwise holds its value.

## Timing
- Reset values: `Dout`=0, `count`=0, `pndng`=0, `full`=0, `empty`=1, `almost_full`=0 (AF_LVL>0), `almost_empty`=1, `overflow`=0, `underflow`=0; both pointers 0.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for `clk`; stored data is discarded.
- Push latency: a word pushed at edge N counts in `count`/flags after edge N. FWFT=1 into an empty FIFO: the word appears on `Dout` after edge N (1 cycle).
- FWFT=1 pop at edge N: the next word (or 0 if now empty) appears on `Dout` after edge N.
- FWFT=0 pop at edge N: the popped word appears on `Dout` after edge N and holds until the next pop_ok.
- Error flags are set on the edge where the rejection happens and are visible after that edge.
- Max throughput: one push and one pop per cycle; no bubbles.

## Test plan
- Fill/drain, DEPTH=16, FWFT=1: push 0..15 on consecutive cycles → `full`=1 and count=16 after the 16th edge, `almost_full` from count 14. Pop 16 times → `Dout` sequence 0..15, then `empty`=1 and `Dout`=0.
- Overflow/underflow: at full, push 0xAAAA alone → count stays 16, `overflow`=1, the 0xAAAA word is never popped. At empty, pop → `underflow`=1. `clr_err` pulse → both flags 0. `clr_err` in the same cycle as a new rejected push → `overflow` stays 1.
- Simultaneous push/pop: at full, push 0x55 + pop → count 16, no overflow, 0x55 is the last word out. At empty, push 0x77 + pop → count 1, `underflow`=1, `Dout`=0x77.
- Wrap-around, DEPTH=5: run 23 interleaved pushes/pops at a varying fill level → every word is read back in order and `count` never exceeds 5.
- FWFT=0: push 1,2,3, then pop at edges N and N+2 → `Dout`=1 after N, still 1 after N+1, 2 after N+2.
- Reset mid-operation: with count=9 and `overflow`=1, drive `rst`=0 between clock edges → all outputs take reset values before the next edge. After release, push 0x12 → `Dout`=0x12 (FWFT=1).
